// File: rtl/reg_wb_queue_pkg.sv
// Shared constants and entry type for the register-file write-back queue.
package reg_wb_queue_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 4;
  localparam int REG_COUNT  = 16;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/reg_wb_queue_wb_fifo.sv
// Generic circular buffer: head/tail/count, per-entry valid bits and a
// visible entry array so the parent can run associative compares.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 36
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush_i,
  input  logic                        push_i,
  input  logic [W-1:0]                push_data_i,
  input  logic                        pop_i,
  output logic [DEPTH-1:0][W-1:0]     entries_o,
  output logic [DEPTH-1:0]            valid_o,
  output logic [$clog2(DEPTH)-1:0]    head_ptr_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [$clog2(DEPTH):0]      count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]        valid_q, valid_d;
  logic [PW-1:0]           head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    full_s, empty_s, do_push_s, do_pop_s;

  assign full_s     = (count_q == CW'(DEPTH));
  assign empty_s    = (count_q == {CW{1'b0}});
  assign do_push_s  = push_i && !full_s;
  assign do_pop_s   = pop_i && !empty_s;
  assign entries_o  = mem_q;
  assign valid_o    = valid_q;
  assign head_ptr_o = head_q;
  assign full_o     = full_s;
  assign empty_o    = empty_s;
  assign count_o    = count_q;

  // Flush wins over push and pop; pointers wrap naturally at power-of-two DEPTH.
  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      valid_d = {DEPTH{1'b0}};
      head_d  = {PW{1'b0}};
      tail_d  = {PW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_d[tail_q]   = push_data_i;
        valid_d[tail_q] = 1'b1;
        tail_d          = tail_q + PW'(1);
      end else begin
        tail_d = tail_q;
      end
      if (do_pop_s) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + PW'(1);
      end else begin
        head_d = head_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      valid_q <= {DEPTH{1'b0}};
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      mem_q   <= mem_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/reg_wb_queue.sv
// Write-back queue feeding the register-file write port from load and ALU.
// Optional forwarding outputs are enabled by defining REG_WB_QUEUE_FWD_EN.
module reg_wb_queue
  import reg_wb_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [ADDR_W-1:0]        ld_rd,
  input  logic [DATA_W-1:0]        ld_data,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_rd,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     rf_grant,
  output logic                     rf_w_en,
  output logic [ADDR_W-1:0]        rf_rd_addr,
  output logic [DATA_W-1:0]        rf_rd_data,
  input  logic [ADDR_W-1:0]        chk_rn_addr,
  input  logic [ADDR_W-1:0]        chk_rm_addr,
  output logic                     rn_pending,
  output logic                     rm_pending,
`ifdef REG_WB_QUEUE_FWD_EN
  output logic                     rn_fwd_hit,
  output logic                     rm_fwd_hit,
  output logic [DATA_W-1:0]        rn_fwd_data,
  output logic [DATA_W-1:0]        rm_fwd_data,
`endif
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int W  = ADDR_W + DATA_W;

  logic [DEPTH-1:0][W-1:0] entries_s;
  logic [DEPTH-1:0]        valid_s;
  logic [PW-1:0]           head_ptr_s;
  logic [W-1:0]            head_entry_s, push_data_s;
  logic                    full_s, empty_s, push_s, pop_s;

  assign ld_ready    = !full_s && !flush;
  assign alu_ready   = !full_s && !flush && !ld_valid;
  assign push_s      = (ld_valid && ld_ready) || (alu_valid && alu_ready);
  assign push_data_s = ld_valid ? {ld_rd, ld_data} : {alu_rd, alu_data};
  assign pop_s       = !empty_s && rf_grant && !flush;

  wb_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .push_i      (push_s),
    .push_data_i (push_data_s),
    .pop_i       (pop_s),
    .entries_o   (entries_s),
    .valid_o     (valid_s),
    .head_ptr_o  (head_ptr_s),
    .full_o      (full_s),
    .empty_o     (empty_s),
    .count_o     (count)
  );

  assign head_entry_s = entries_s[head_ptr_s];
  assign rf_w_en      = pop_s;
  assign rf_rd_addr   = empty_s ? {ADDR_W{1'b0}} : head_entry_s[DATA_W +: ADDR_W];
  assign rf_rd_data   = empty_s ? {DATA_W{1'b0}} : head_entry_s[DATA_W-1:0];

  // Associative compare against registered entries only; scanning from head
  // means the last match seen is the youngest one.
  always_comb begin
    logic [PW-1:0] idx_s;
    rn_pending = 1'b0;
    rm_pending = 1'b0;
`ifdef REG_WB_QUEUE_FWD_EN
    rn_fwd_hit  = 1'b0;
    rm_fwd_hit  = 1'b0;
    rn_fwd_data = {DATA_W{1'b0}};
    rm_fwd_data = {DATA_W{1'b0}};
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx_s = head_ptr_s + PW'(k);
      if (valid_s[idx_s] && (entries_s[idx_s][DATA_W +: ADDR_W] == chk_rn_addr)) begin
        rn_pending = 1'b1;
`ifdef REG_WB_QUEUE_FWD_EN
        rn_fwd_hit  = 1'b1;
        rn_fwd_data = entries_s[idx_s][DATA_W-1:0];
`endif
      end else begin
        rn_pending = rn_pending;
      end
      if (valid_s[idx_s] && (entries_s[idx_s][DATA_W +: ADDR_W] == chk_rm_addr)) begin
        rm_pending = 1'b1;
`ifdef REG_WB_QUEUE_FWD_EN
        rm_fwd_hit  = 1'b1;
        rm_fwd_data = entries_s[idx_s][DATA_W-1:0];
`endif
      end else begin
        rm_pending = rm_pending;
      end
    end
  end
endmodule
